// File: rtl/systolic_sequencer_if.sv
// Host-side command, weight and pixel streams plus the array-side strobes
// of the systolic sequencer, bundled as one port.
interface systolic_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              wgt_in_valid;
    logic [DATA_W-1:0] wgt_in_data;
    logic              wgt_in_ready;
    logic              wgt_load;
    logic [7:0]        wgt_idx;
    logic [DATA_W-1:0] wgt_data;
    logic              pix_in_valid;
    logic [DATA_W-1:0] pix_in_data;
    logic              pix_in_ready;
    logic              pix_out_valid;
    logic [DATA_W-1:0] pix_out_data;
    logic [7:0]        pix_row;
    logic [7:0]        pix_col;
    logic              window_valid;
    logic [31:0]       cycle_cnt;
    logic [31:0]       stall_cnt;

    // master: host/stream side; slave: the sequencer itself
    modport master (
        output start, abort, wgt_in_valid, wgt_in_data, pix_in_valid, pix_in_data,
        input  busy, done, wgt_in_ready, wgt_load, wgt_idx, wgt_data, pix_in_ready,
               pix_out_valid, pix_out_data, pix_row, pix_col, window_valid,
               cycle_cnt, stall_cnt
    );
    modport slave (
        input  start, abort, wgt_in_valid, wgt_in_data, pix_in_valid, pix_in_data,
        output busy, done, wgt_in_ready, wgt_load, wgt_idx, wgt_data, pix_in_ready,
               pix_out_valid, pix_out_data, pix_row, pix_col, window_valid,
               cycle_cnt, stall_cnt
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Job controller for the 2D systolic convolution array: weight load, raster pixel
// stream, pipeline drain, done pulse. SYSTOLIC_SEQ_PERF_CNT_EN adds cycle/stall counters.
module systolic_sequencer #(
    parameter int IMG_WIDTH   = 3,
    parameter int IMG_HEIGHT  = 6,
    parameter int KERNEL_SIZE = 2,
    parameter int PIPE_LAT    = 4,
    parameter int DATA_W      = 8
) (
    input logic clk,
    input logic rst,
    systolic_sequencer_if.slave bus
);
    localparam int NUM_W     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WIN_TOTAL = (IMG_WIDTH - KERNEL_SIZE + 1) * (IMG_HEIGHT - KERNEL_SIZE + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]  w_cnt, row_cnt, col_cnt;
    logic [15:0] drain_cnt, win_cnt;
    logic        wgt_hs, pix_hs, last_w, last_pix, drain_end, win_hit, job_start;

    // abort masks ready so a coincident handshake is never consumed
    assign bus.wgt_in_ready = (state == S_LOAD_W) && !bus.abort;
    assign bus.pix_in_ready = (state == S_STREAM) && !bus.abort;
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE);

    assign wgt_hs    = bus.wgt_in_valid && bus.wgt_in_ready;
    assign pix_hs    = bus.pix_in_valid && bus.pix_in_ready;
    assign last_w    = (w_cnt == 8'(NUM_W - 1));
    assign last_pix  = (row_cnt == 8'(IMG_HEIGHT - 1)) && (col_cnt == 8'(IMG_WIDTH - 1));
    assign drain_end = (drain_cnt == 16'(PIPE_LAT));
    assign win_hit   = pix_hs && (row_cnt >= 8'(KERNEL_SIZE - 1)) && (col_cnt >= 8'(KERNEL_SIZE - 1));
    assign job_start = (state == S_IDLE) && bus.start && !bus.abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (job_start)          state_nxt = S_LOAD_W;
            S_LOAD_W: if (wgt_hs && last_w)   state_nxt = S_STREAM;
            S_STREAM: if (pix_hs && last_pix) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_end)          state_nxt = S_DONE;
            S_DONE:                           state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
        if (bus.abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt             <= '0;
            row_cnt           <= '0;
            col_cnt           <= '0;
            drain_cnt         <= '0;
            win_cnt           <= '0;
            bus.wgt_load      <= 1'b0;
            bus.wgt_idx       <= '0;
            bus.wgt_data      <= '0;
            bus.pix_out_valid <= 1'b0;
            bus.pix_out_data  <= '0;
            bus.pix_row       <= '0;
            bus.pix_col       <= '0;
            bus.window_valid  <= 1'b0;
        end else if (bus.abort || job_start) begin
            w_cnt             <= '0;
            row_cnt           <= '0;
            col_cnt           <= '0;
            drain_cnt         <= '0;
            win_cnt           <= '0;
            bus.wgt_load      <= 1'b0;
            bus.pix_out_valid <= 1'b0;
            bus.window_valid  <= 1'b0;
        end else begin
            bus.wgt_load      <= wgt_hs;
            bus.pix_out_valid <= pix_hs;
            bus.window_valid  <= win_hit;
            drain_cnt         <= (state == S_DRAIN) ? drain_cnt + 16'd1 : '0;
            if (wgt_hs) begin
                bus.wgt_idx  <= w_cnt;
                bus.wgt_data <= bus.wgt_in_data;
                w_cnt        <= w_cnt + 8'd1;
            end
            if (pix_hs) begin
                bus.pix_out_data <= bus.pix_in_data;
                bus.pix_row      <= row_cnt;
                bus.pix_col      <= col_cnt;
                if (col_cnt == 8'(IMG_WIDTH - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 8'd1;
                end else begin
                    col_cnt <= col_cnt + 8'd1;
                end
            end
            if (win_hit) win_cnt <= win_cnt + 16'd1;
        end
    end

    // every completed job must have produced exactly one strobe per window position
    assert property (@(posedge clk) disable iff (rst)
        (state == S_DONE) |-> (win_cnt == 16'(WIN_TOTAL)));

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    logic [31:0] cycle_q, stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else if ((bus.abort && state != S_IDLE) || job_start) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else if (state != S_IDLE) begin
            cycle_q <= cycle_q + 32'd1;
            if (state == S_STREAM && !bus.pix_in_valid) stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.cycle_cnt = cycle_q;
    assign bus.stall_cnt = stall_q;
`else
    assign bus.cycle_cnt = '0;
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: a K=2 and a K=1 instance on a 3x6 image,
// table-driven jobs plus abort, start-while-busy and mid-drain reset sequences.
module tb_systolic_sequencer;
    localparam int W = 3, H = 6, PL = 4, DW = 8;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start, abort, wvalid, pvalid, sel;
    logic [DW-1:0] wdata, pdata;

    systolic_sequencer_if #(.DATA_W(DW)) b0 ();
    systolic_sequencer_if #(.DATA_W(DW)) b1 ();

    assign b0.start = start && !sel;         assign b1.start = start && sel;
    assign b0.abort = abort && !sel;         assign b1.abort = abort && sel;
    assign b0.wgt_in_valid = wvalid;         assign b1.wgt_in_valid = wvalid;
    assign b0.wgt_in_data  = wdata;          assign b1.wgt_in_data  = wdata;
    assign b0.pix_in_valid = pvalid;         assign b1.pix_in_valid = pvalid;
    assign b0.pix_in_data  = pdata;          assign b1.pix_in_data  = pdata;

    systolic_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(2), .PIPE_LAT(PL), .DATA_W(DW))
        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    systolic_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(1), .PIPE_LAT(PL), .DATA_W(DW))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // observed outputs of whichever instance the current job targets
    logic          m_busy, m_done, m_wrdy, m_prdy, m_wload, m_pvld, m_win;
    logic [7:0]    m_widx, m_row, m_col;
    logic [DW-1:0] m_wdat, m_pdat;
    logic [31:0]   m_cyc, m_stall;
    assign m_busy  = sel ? b1.busy          : b0.busy;
    assign m_done  = sel ? b1.done          : b0.done;
    assign m_wrdy  = sel ? b1.wgt_in_ready  : b0.wgt_in_ready;
    assign m_prdy  = sel ? b1.pix_in_ready  : b0.pix_in_ready;
    assign m_wload = sel ? b1.wgt_load      : b0.wgt_load;
    assign m_widx  = sel ? b1.wgt_idx       : b0.wgt_idx;
    assign m_wdat  = sel ? b1.wgt_data      : b0.wgt_data;
    assign m_pvld  = sel ? b1.pix_out_valid : b0.pix_out_valid;
    assign m_pdat  = sel ? b1.pix_out_data  : b0.pix_out_data;
    assign m_row   = sel ? b1.pix_row       : b0.pix_row;
    assign m_col   = sel ? b1.pix_col       : b0.pix_col;
    assign m_win   = sel ? b1.window_valid  : b0.window_valid;
    assign m_cyc   = sel ? b1.cycle_cnt     : b0.cycle_cnt;
    assign m_stall = sel ? b1.stall_cnt     : b0.stall_cnt;

    typedef struct {
        bit sel;      bit stall;
        int wgt;      int pix;      int win;
        int done_at;  int stall_n;  int cycles;
    } vec_t;
    vec_t tbl[3];

    int  n_chk = 0, n_pass = 0;
    int  cyc, n_wl, n_po, n_win, n_done, done_cyc, w_src, p_src, kk;
    bit  stall_mode;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    task automatic job_begin(input bit s, input bit stl);
        sel = s; kk = s ? 1 : 2; stall_mode = stl;
        cyc = 0; n_wl = 0; n_po = 0; n_win = 0; n_done = 0; done_cyc = -1;
        w_src = 0; p_src = 0;
        wdata = 8'hA0; pdata = 8'h40; wvalid = 1'b1; pvalid = 1'b1;
    endtask

    // one clock: note handshakes before the edge, check outputs after it, update sources
    task automatic tick();
        bit hw, hp;
        int r, c;
        hw = wvalid && m_wrdy;
        hp = pvalid && m_prdy;
        @(posedge clk); #1;
        cyc++;
        if (hw) w_src++;
        if (hp) p_src++;
        if (m_wload) begin
            chk("wgt_idx", m_widx, n_wl);
            chk("wgt_data", m_wdat, 32'hA0 + n_wl);
            n_wl++;
        end
        if (m_pvld) begin
            r = n_po / W; c = n_po % W;
            chk("pix_row", m_row, r);
            chk("pix_col", m_col, c);
            chk("pix_data", m_pdat, 32'h40 + n_po);
            chk("window_valid", m_win, (r >= kk - 1) && (c >= kk - 1));
            n_po++;
            if (m_win) n_win++;
        end else begin
            chk("window_idle", m_win, 0);
        end
        if (m_done) begin n_done++; done_cyc = cyc; end
        wdata  = 8'(8'hA0 + w_src);
        pdata  = 8'(8'h40 + p_src);
        pvalid = stall_mode ? (cyc % 2 == 0) : 1'b1;
    endtask

    task automatic run_job(input bit s, input bit stl);
        job_begin(s, stl);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 200 && n_done == 0; i++) tick();
        tick();
    endtask

    task automatic check_job(input vec_t v);
        chk("wgt_count", n_wl, v.wgt);
        chk("pix_count", n_po, v.pix);
        chk("window_count", n_win, v.win);
        chk("done_count", n_done, 1);
        chk("done_cycle", done_cyc, v.done_at);
        chk("busy_after", m_busy, 0);
        chk("done_after", m_done, 0);
        chk("cycle_cnt", m_cyc, PERF ? v.cycles : 0);
        chk("stall_cnt", m_stall, PERF ? v.stall_n : 0);
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_busy"}, b0.busy, 0);           chk({t, "_done"}, b0.done, 0);
        chk({t, "_wrdy"}, b0.wgt_in_ready, 0);   chk({t, "_prdy"}, b0.pix_in_ready, 0);
        chk({t, "_wload"}, b0.wgt_load, 0);      chk({t, "_widx"}, b0.wgt_idx, 0);
        chk({t, "_wdata"}, b0.wgt_data, 0);      chk({t, "_pvld"}, b0.pix_out_valid, 0);
        chk({t, "_pdata"}, b0.pix_out_data, 0);  chk({t, "_row"}, b0.pix_row, 0);
        chk({t, "_col"}, b0.pix_col, 0);         chk({t, "_win"}, b0.window_valid, 0);
        chk({t, "_cyc"}, b0.cycle_cnt, 0);       chk({t, "_stall"}, b0.stall_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{sel: 1'b0, stall: 1'b0, wgt: 4, pix: 18, win: 10, done_at: 28, stall_n: 0,  cycles: 28};
        tbl[1] = '{sel: 1'b0, stall: 1'b1, wgt: 4, pix: 18, win: 10, done_at: 46, stall_n: 18, cycles: 46};
        tbl[2] = '{sel: 1'b1, stall: 1'b0, wgt: 1, pix: 18, win: 18, done_at: 25, stall_n: 0,  cycles: 25};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        job_begin(1'b0, 1'b0);
        wvalid = 1'b0; pvalid = 1'b0;
        #12;
        chk_reset("reset");
        rst = 1'b0;
        wvalid = 1'b1; pvalid = 1'b1;
        tick(); tick();

        for (int i = 0; i < 3; i++) begin
            run_job(tbl[i].sel, tbl[i].stall);
            check_job(tbl[i]);
            tick();
        end

        // abort on the 7th pixel handshake cycle, then a clean job
        job_begin(1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        while (cyc < 11) tick();
        abort = 1'b1; #1;
        chk("abort_ready", m_prdy, 0);
        tick(); abort = 1'b0;
        chk("abort_busy", m_busy, 0);
        chk("abort_pvld", m_pvld, 0);
        chk("abort_pix_count", n_po, 6);
        chk("abort_pix_consumed", p_src, 6);
        chk("abort_cycle_cnt", m_cyc, 0);
        repeat (5) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", m_busy, 0);
        run_job(1'b0, 1'b0);
        check_job(tbl[0]);

        // start pulses during STREAM and in the DONE cycle are ignored
        job_begin(1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            start = (cyc == 12);
            tick();
        end
        start = 1'b0;
        chk("ign_in_done", m_done, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("ign_busy", m_busy, 0);
        repeat (4) tick();
        chk("ign_done_count", n_done, 1);
        chk("ign_done_cycle", done_cyc, 28);
        chk("ign_pix_count", n_po, 18);
        chk("ign_wgt_count", n_wl, 4);
        chk("ign_idle", m_busy, 0);

        // asynchronous reset while draining, then a clean job
        job_begin(1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        while (cyc < 23) tick();
        chk("drain_busy", m_busy, 1);
        rst = 1'b1; #1;
        chk_reset("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(1'b0, 1'b0);
        check_job(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
Top-level controller for the 2D systolic convolution array. On a start command it loads KERNEL_SIZE×KERNEL_SIZE weights into the PE grid, then streams an IMG_WIDTH×IMG_HEIGHT image in raster order. It generates the window_valid strobe consumed by the output-valid FSM, waits out the pipeline drain, and reports completion. It sits between the host-side weight/pixel streams and the array datapath.

Parameters:
IMG_WIDTH, 3, image columns (KERNEL_SIZE ≤ IMG_WIDTH ≤ 255)
IMG_HEIGHT, 6, image rows (KERNEL_SIZE ≤ IMG_HEIGHT ≤ 255)
KERNEL_SIZE, 2, kernel edge length (≥1)
PIPE_LAT, 4, array pipeline latency to drain after the last pixel
DATA_W, 8, pixel/weight width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin job; sampled only in IDLE
abort  in  1  synchronous cancel; return to IDLE, no done
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
wgt_in_valid  in  1  weight source valid
wgt_in_data  in  DATA_W  weight value
wgt_in_ready  out  1  high only in LOAD_W
wgt_load  out  1  registered weight-write strobe to the array
wgt_idx  out  8  weight index 0..K*K-1, raster order
wgt_data  out  DATA_W  registered weight
pix_in_valid  in  1  pixel source valid
pix_in_data  in  DATA_W  pixel value
pix_in_ready  out  1  high only in STREAM
pix_out_valid  out  1  registered pixel strobe to the array
pix_out_data  out  DATA_W  registered pixel
pix_row  out  8  row of the current pix_out pixel
pix_col  out  8  column of the current pix_out pixel
window_valid  out  1  pixel completes a full KxK window
cycle_cnt  out  32  job cycle count (optional feature)
stall_cnt  out  32  STREAM cycles without a handshake (optional feature)

Behaviour:
- Reset: reset is rst, asynchronous, active-high; clock is clk. On reset, state is IDLE and all outputs, counters and registered data are 0.
- States:
  - IDLE: on start=1, clear counters and go to LOAD_W.
  - LOAD_W: on the K*K-th weight handshake, go to STREAM.
  - STREAM: on the handshake of pixel (H-1, W-1), go to DRAIN.
  - DRAIN: after PIPE_LAT+1 cycles, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- A handshake occurs when valid && ready in the same cycle. Ready is a decode of state only; it never depends on valid.
- Weight handshake: in the next cycle, wgt_load=1, wgt_idx=handshake index, wgt_data=wgt_in_data. Otherwise wgt_load=0; wgt_idx and wgt_data hold.
- Pixel handshake: in the next cycle, pix_out_valid=1 and pix_out_data/pix_row/pix_col describe that pixel.
- window_valid = pix_out_valid && pix_row ≥ K-1 && pix_col ≥ K-1, registered in the same cycle as pix_out_valid.
- Column counter wraps from W-1 to 0 and increments row. Row never wraps within a job.
- No handshake in a cycle: pix_out_valid=0 and window_valid=0; counters hold. Source stalls are legal at any point.
- window_valid pulses per job = (W-K+1)*(H-K+1). An internal counter checks this; K=1 makes every pixel valid.
- start while busy is ignored.
- abort in any non-IDLE state: next cycle is IDLE, all strobes are 0, done is not pulsed, partial counts are discarded. abort has priority over a handshake in the same cycle; the handshake is not consumed (ready is forced to 0 that cycle). abort in IDLE is a no-op; abort+start in IDLE gives IDLE.
- Back-to-back jobs: start sampled in the cycle done is high is ignored, because state is still DONE. The next job starts at the earliest in the first IDLE cycle.
- Fixed latency with no stalls: done is high exactly 1 + K*K + W*H + PIPE_LAT + 1 cycles after the edge that samples start (28 for defaults).

Optional Feature:
SYSTOLIC_SEQ_PERF_CNT_EN.
- Defined:
  - cycle_cnt clears when start is accepted and increments every busy cycle, including DONE; it holds after done until the next start.
  - stall_cnt increments on every STREAM cycle with pix_in_valid=0; it holds likewise.
  - abort clears both counters.
- Undefined: cycle_cnt and stall_cnt are constant 0 and no counter logic is generated.

Test Plan:
- Defaults, sources always valid, start at t0 → wgt_load pulses 4× (idx 0..3) → 18 pix_out_valid → 10 window_valid pulses (pixels at row≥1, col≥1) → done one cycle at t0+28 → busy=0 next cycle.
- Pixel source deasserts valid every other cycle → pix_out_valid only after handshakes, row/col correct, still 10 windows → done delayed by 18 cycles; stall_cnt=18 with the macro defined.
- abort asserted on the 7th pixel handshake cycle → that pixel not consumed, IDLE next cycle, no done, busy=0 → a following start runs a full job with 4 weights and 18 pixels.
- start pulsed during STREAM and in the DONE cycle → ignored; exactly one done pulse; IDLE is reached.
- rst asserted mid-DRAIN → all outputs 0 immediately (asynchronous) → after release, start runs a clean job matching the first scenario.
- KERNEL_SIZE=1, IMG 3×6 → 1 weight, 18 window_valid pulses (every pixel) → done at start+1+1+18+5=25.
